imem_boot_loader: RTL and testbench

Sequences the write side of the single-cycle core's instruction memory at power-up or reload. Accepts a byte stream over a valid/ready handshake and packs it into 32-bit words. Writes the words to consecutive word addresses, optionally zero-fills (NOP) the rest of the memory, and holds the processor in reset until the image is complete. Sits between the host/UART byte source and the instruction memory write port; the fetch path stays read-only.

---
 rtl/imem_boot_loader_pkg.sv | 17 +
 rtl/imem_boot_loader_if.sv | 24 ++
 rtl/imem_boot_loader_byte_packer.sv | 40 ++++
 rtl/imem_boot_loader.sv | 122 ++++++++++++
 tb/tb_imem_boot_loader.sv | 379 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/imem_boot_loader_pkg.sv
// Shared types and sizes for the instruction-memory boot loader.
// The fill value and the default memory geometry live here so the loader and packer agree.
package imem_pkg;

   localparam int          IMEM_ADDR_W = 8;
   localparam int          IMEM_DEPTH  = 1 << IMEM_ADDR_W;
   localparam logic [31:0] NOP_WORD    = 32'h0;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      WRITE,
      FILL,
      DONE
   } state_t;

endpackage

// File: rtl/imem_boot_loader_if.sv
// Byte-stream input and instruction-memory write port of the boot loader.
// slave is the loader's view; master is the byte source / memory side.
interface imem_boot_loader_if #(
   parameter int ADDR_W = 8
) ();

   logic              byte_valid;
   logic [7:0]        byte_data;
   logic              byte_ready;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_waddr;
   logic [31:0]       mem_wdata;

   modport master (
      output byte_valid, byte_data,
      input  byte_ready, mem_we, mem_waddr, mem_wdata
   );

   modport slave (
      input  byte_valid, byte_data,
      output byte_ready, mem_we, mem_waddr, mem_wdata
   );

endinterface

// File: rtl/imem_boot_loader_byte_packer.sv
// Packs four bytes into a 32-bit word in either byte order.
// word_ready flags the push that completes a word; clear reloads the fill value.
module imem_byte_packer
   import imem_pkg::*;
#(
   parameter bit BIG_ENDIAN = 1'b1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        push,
   input  logic        clear,
   input  logic [7:0]  data,
   output logic [31:0] word,
   output logic        word_ready
);

   logic [31:0] sr;
   logic [1:0]  idx;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sr  <= '0;
         idx <= '0;
      end else if (clear) begin
         sr  <= NOP_WORD;
         idx <= '0;
      end else if (push) begin
         // Four pushes fully overwrite the word, so no clear is needed between words.
         if (BIG_ENDIAN)
            sr <= {sr[23:0], data};
         else
            sr <= {data, sr[31:8]};
         idx <= idx + 2'd1;
      end
   end

   assign word       = sr;
   assign word_ready = push && (idx == 2'd3);

endmodule

// File: rtl/imem_boot_loader.sv
// Loads a byte-streamed image into instruction memory, optionally zero-fills the rest,
// and holds the core in reset until the image is complete or aborted.
module imem_boot_loader
   import imem_pkg::*;
#(
   parameter int ADDR_W     = IMEM_ADDR_W,
   parameter bit BIG_ENDIAN = 1'b1,
   parameter bit FILL_NOP   = 1'b1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [ADDR_W:0]   word_count,
   input  logic              abort,
   imem_boot_loader_if.slave bus,
   output logic              cpu_hold,
   output logic              busy,
   output logic              done,
   output logic              err
);

   localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W+1)'(1 << ADDR_W);

   state_t            state;
   state_t            state_nx;
   logic [ADDR_W:0]   count;
   logic [ADDR_W-1:0] ptr;
   logic [ADDR_W:0]   ptr_inc;
   logic              start_ok;
   logic              accept;
   logic              pk_clear;
   logic              word_ready;
   logic [31:0]       pk_word;
   logic              mem_we_q;
   logic              ptr_step;

   assign ptr_inc  = {1'b0, ptr} + (ADDR_W+1)'(1);
   assign start_ok = start && (word_count != '0) && (word_count <= DEPTH_W);
   assign accept   = bus.byte_valid && (state == LOAD);
   // The packer register doubles as the write-data register; clearing it on entry to FILL yields NOP words.
   assign pk_clear = ((state == IDLE) && start_ok) || ((state == WRITE) && (state_nx == FILL));
   assign ptr_step = ((state == WRITE) && ((state_nx == LOAD) || (state_nx == FILL))) ||
                     ((state == FILL) && (state_nx == FILL));

   imem_byte_packer #(.BIG_ENDIAN(BIG_ENDIAN)) u_packer (
      .clk        (clk),
      .rst_n      (rst_n),
      .push       (accept),
      .clear      (pk_clear),
      .data       (bus.byte_data),
      .word       (pk_word),
      .word_ready (word_ready)
   );

   assign bus.byte_ready = (state == LOAD);
   assign bus.mem_we     = mem_we_q;
   assign bus.mem_waddr  = ptr;
   assign bus.mem_wdata  = pk_word;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= IDLE;
      else
         state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:  if (start_ok) state_nx = LOAD;
         LOAD: begin
            if (abort)           state_nx = IDLE;
            else if (word_ready) state_nx = WRITE;
         end
         WRITE: begin
            if (abort)                                  state_nx = IDLE;
            else if (ptr_inc < count)                   state_nx = LOAD;
            else if (FILL_NOP && (count < DEPTH_W))     state_nx = FILL;
            else                                        state_nx = DONE;
         end
         FILL: begin
            if (abort)      state_nx = IDLE;
            else if (&ptr)  state_nx = DONE;
         end
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count    <= '0;
         ptr      <= '0;
         mem_we_q <= 1'b0;
         cpu_hold <= 1'b1;
         busy     <= 1'b0;
         done     <= 1'b0;
         err      <= 1'b0;
      end else begin
         mem_we_q <= (state_nx == WRITE) || (state_nx == FILL);
         busy     <= (state_nx != IDLE);
         done     <= (state_nx == DONE);

         if ((state == IDLE) && start) begin
            err <= !start_ok;
            if (start_ok) begin
               count    <= word_count;
               ptr      <= '0;
               cpu_hold <= 1'b1;
            end
         end else begin
            if (abort && (state inside {LOAD, WRITE, FILL}))
               err <= 1'b1;
            if (ptr_step)
               ptr <= ptr + ADDR_W'(1);
            if (state == DONE)
               cpu_hold <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Bench for imem_boot_loader: two instances (big-endian with fill, little-endian without)
// share stimulus through a select line; a write log is compared with a byte-level model.
module tb_imem_boot_loader;
   import imem_pkg::*;

   localparam int AW    = IMEM_ADDR_W;
   localparam int DEPTH = 256;

   logic          clk        = 1'b0;
   logic          rst_n      = 1'b0;
   logic          sel        = 1'b0;
   logic          start      = 1'b0;
   logic          abort      = 1'b0;
   logic          byte_valid = 1'b0;
   logic [7:0]    byte_data  = '0;
   logic [AW:0]   word_count = '0;

   imem_boot_loader_if #(.ADDR_W(AW)) if_a ();
   imem_boot_loader_if #(.ADDR_W(AW)) if_b ();

   logic cpu_hold_a, busy_a, done_a, err_a;
   logic cpu_hold_b, busy_b, done_b, err_b;

   assign if_a.byte_valid = byte_valid & ~sel;
   assign if_a.byte_data  = byte_data;
   assign if_b.byte_valid = byte_valid & sel;
   assign if_b.byte_data  = byte_data;

   imem_boot_loader #(.ADDR_W(AW), .BIG_ENDIAN(1'b1), .FILL_NOP(1'b1)) dut_a (
      .clk(clk), .rst_n(rst_n), .start(start & ~sel), .word_count(word_count),
      .abort(abort & ~sel), .bus(if_a.slave),
      .cpu_hold(cpu_hold_a), .busy(busy_a), .done(done_a), .err(err_a)
   );

   imem_boot_loader #(.ADDR_W(AW), .BIG_ENDIAN(1'b0), .FILL_NOP(1'b0)) dut_b (
      .clk(clk), .rst_n(rst_n), .start(start & sel), .word_count(word_count),
      .abort(abort & sel), .bus(if_b.slave),
      .cpu_hold(cpu_hold_b), .busy(busy_b), .done(done_b), .err(err_b)
   );

   logic          o_rdy, o_we, o_hold, o_busy, o_done, o_err;
   logic [AW-1:0] o_waddr;
   logic [31:0]   o_wdata;

   assign o_rdy   = sel ? if_b.byte_ready : if_a.byte_ready;
   assign o_we    = sel ? if_b.mem_we     : if_a.mem_we;
   assign o_waddr = sel ? if_b.mem_waddr  : if_a.mem_waddr;
   assign o_wdata = sel ? if_b.mem_wdata  : if_a.mem_wdata;
   assign o_hold  = sel ? cpu_hold_b      : cpu_hold_a;
   assign o_busy  = sel ? busy_b          : busy_a;
   assign o_done  = sel ? done_b          : done_a;
   assign o_err   = sel ? err_b           : err_a;

   always #5 clk = ~clk;

   int          n_checks = 0;
   int          n_fail   = 0;
   int          cyc      = 0;
   int          t0       = 0;
   int          hold_fall = -1;
   int          rdy_in_write = 0;
   int          wr_addr[$];
   logic [31:0] wr_data[$];
   int          wr_cyc[$];
   int          done_cyc[$];
   logic [7:0]  img[$];
   int          ex_addr[$];
   logic [31:0] ex_data[$];
   int          ex_cyc[$];

   always @(posedge clk) cyc <= cyc + 1;

   // Event cycle numbers are relative to the edge that accepted start (cycle 0).
   always @(negedge clk) begin : mon
      int c;
      c = cyc + 1 - t0;
      if (rst_n) begin
         if (o_we) begin
            wr_addr.push_back(int'(o_waddr));
            wr_data.push_back(o_wdata);
            wr_cyc.push_back(c);
            if (o_rdy) rdy_in_write = rdy_in_write + 1;
         end
         if (o_done) done_cyc.push_back(c);
         if (!o_hold && hold_fall < 0 && c >= 1) hold_fall = c;
      end
   end

   task automatic clear_mon();
      wr_addr.delete(); wr_data.delete(); wr_cyc.delete(); done_cyc.delete();
      hold_fall    = -1;
      rdy_in_write = 0;
      t0           = cyc + 1;
   endtask

   task automatic gen_img(int nbytes);
      img.delete();
      for (int i = 0; i < nbytes; i++) img.push_back(8'($urandom_range(0, 255)));
   endtask

   // Reference: word k is bytes 4k..4k+3 in the chosen order at address k, written in cycle 5(k+1);
   // fill words follow one per cycle at the remaining addresses.
   function automatic void build_expected(int n, bit be, bit fill);
      logic [31:0] w;
      ex_addr.delete(); ex_data.delete(); ex_cyc.delete();
      for (int k = 0; k < n; k++) begin
         w = 32'h0;
         for (int j = 0; j < 4; j++) begin
            if (be) w = w * 256 + 32'(img[4*k+j]);
            else    w = w + (32'(img[4*k+j]) << (8*j));
         end
         ex_addr.push_back(k); ex_data.push_back(w); ex_cyc.push_back(5*(k+1));
      end
      if (fill && n < DEPTH)
         for (int a = n; a < DEPTH; a++) begin
            ex_addr.push_back(a); ex_data.push_back(32'h0); ex_cyc.push_back(5*n + 1 + (a - n));
         end
   endfunction

   task automatic do_start(int n);
      @(posedge clk); #1;
      clear_mon();
      @(negedge clk);
      start = 1'b1; word_count = (AW+1)'(n);
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic send_byte(logic [7:0] b, int gap);
      int n;
      n = 0;
      byte_valid = 1'b1; byte_data = b;
      while (!o_rdy && n < 400) begin
         @(negedge clk); start = 1'b0; n++;
      end
      if (!o_rdy) begin
         n_checks++; n_fail++;
         $display("FAIL byte_accept: byte_ready=0 after 400 cycles, required 1");
      end
      @(negedge clk);
      start = 1'b0; byte_valid = 1'b0;
      repeat (gap) @(negedge clk);
   endtask

   task automatic send_img(int gap, int spur);
      for (int i = 0; i < img.size(); i++) begin
         if (i == spur) begin start = 1'b1; word_count = (AW+1)'(3); end
         send_byte(img[i], gap);
      end
   endtask

   task automatic wait_idle(int budget);
      int n;
      n = 0;
      while (o_busy && n < budget) begin @(negedge clk); n++; end
      if (o_busy) begin
         n_checks++; n_fail++;
         $display("FAIL idle_timeout: busy=1 after %0d cycles, required 0", budget);
      end
      repeat (2) @(negedge clk);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      for (int s = 0; s < 2; s++) begin
         sel = s[0]; #1;
         n_checks++;
         if ({o_rdy, o_we, o_hold, o_busy, o_done, o_err} !== 6'b001000) begin
            n_fail++;
            $display("FAIL reset_flags[%0d]: rdy/we/hold/busy/done/err=%b, required 001000", s,
                     {o_rdy, o_we, o_hold, o_busy, o_done, o_err});
         end
         n_checks++;
         if (o_waddr !== '0 || o_wdata !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_bus[%0d]: waddr=%0d wdata=%h, required 0 0", s, o_waddr, o_wdata);
         end
      end
      sel = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_big_endian_fill();
      sel = 1'b0;
      img = '{8'h20, 8'h22, 8'h00, 8'h0A, 8'h3C, 8'h01, 8'h00, 8'h0F};
      do_start(2);
      send_img(0, -1);
      wait_idle(3000);
      build_expected(2, 1'b1, 1'b1);
      n_checks++;
      if (wr_addr.size() !== ex_addr.size()) begin
         n_fail++; $display("FAIL be_write_count: got %0d, required %0d", wr_addr.size(), ex_addr.size());
      end
      for (int i = 0; i < ex_addr.size() && i < wr_addr.size(); i++) begin
         n_checks++;
         if (wr_addr[i] !== ex_addr[i] || wr_data[i] !== ex_data[i] || wr_cyc[i] !== ex_cyc[i]) begin
            n_fail++;
            $display("FAIL be_write[%0d]: got a=%0d d=%h c=%0d, required a=%0d d=%h c=%0d", i,
                     wr_addr[i], wr_data[i], wr_cyc[i], ex_addr[i], ex_data[i], ex_cyc[i]);
         end
      end
      n_checks++;
      if (done_cyc.size() != 1 || done_cyc[0] != 5*2 + (DEPTH-2) + 1) begin
         n_fail++; $display("FAIL be_done: %0d pulses first at %0d, required 1 at %0d",
                            done_cyc.size(), (done_cyc.size() > 0) ? done_cyc[0] : -1, 5*2 + (DEPTH-2) + 1);
      end
      n_checks++;
      if (hold_fall != 5*2 + (DEPTH-2) + 2) begin
         n_fail++; $display("FAIL be_hold_fall: got cycle %0d, required %0d", hold_fall, 5*2 + (DEPTH-2) + 2);
      end
   endtask

   task automatic test_little_endian();
      sel = 1'b1;
      img = '{8'h0A, 8'h00, 8'h22, 8'h20};
      do_start(1);
      send_img(0, -1);
      wait_idle(200);
      build_expected(1, 1'b0, 1'b0);
      n_checks++;
      if (wr_addr.size() !== 1) begin
         n_fail++; $display("FAIL le_write_count: got %0d, required 1", wr_addr.size());
      end
      for (int i = 0; i < ex_addr.size() && i < wr_addr.size(); i++) begin
         n_checks++;
         if (wr_addr[i] !== ex_addr[i] || wr_data[i] !== ex_data[i] || wr_cyc[i] !== ex_cyc[i]) begin
            n_fail++;
            $display("FAIL le_write[%0d]: got a=%0d d=%h c=%0d, required a=%0d d=%h c=%0d", i,
                     wr_addr[i], wr_data[i], wr_cyc[i], ex_addr[i], ex_data[i], ex_cyc[i]);
         end
      end
      n_checks++;
      if (done_cyc.size() != 1 || done_cyc[0] != 6) begin
         n_fail++; $display("FAIL le_done: %0d pulses first at %0d, required 1 at 6",
                            done_cyc.size(), (done_cyc.size() > 0) ? done_cyc[0] : -1);
      end
   endtask

   task automatic test_bad_count();
      int bad[2];
      bad[0] = 0; bad[1] = DEPTH + 1;
      sel = 1'b1;
      for (int k = 0; k < 2; k++) begin
         do_start(bad[k]);
         repeat (3) @(negedge clk);
         n_checks++;
         if ({o_err, o_busy, o_hold} !== 3'b100 || wr_addr.size() != 0) begin
            n_fail++;
            $display("FAIL bad_count_%0d: err/busy/hold=%b writes=%0d, required 100 and 0 writes",
                     bad[k], {o_err, o_busy, o_hold}, wr_addr.size());
         end
      end
      gen_img(4);
      do_start(1);
      n_checks++;
      if ({o_err, o_busy, o_hold} !== 3'b011) begin
         n_fail++; $display("FAIL bad_count_recover: err/busy/hold=%b, required 011", {o_err, o_busy, o_hold});
      end
      send_img(0, -1);
      wait_idle(200);
   endtask

   task automatic test_gapped();
      sel = 1'b0;
      gen_img(12);
      do_start(3);
      send_img(3, -1);
      wait_idle(3000);
      build_expected(3, 1'b1, 1'b1);
      n_checks++;
      if (wr_addr.size() !== ex_addr.size()) begin
         n_fail++; $display("FAIL gap_write_count: got %0d, required %0d", wr_addr.size(), ex_addr.size());
      end
      for (int i = 0; i < ex_addr.size() && i < wr_addr.size(); i++) begin
         n_checks++;
         if (wr_addr[i] !== ex_addr[i] || wr_data[i] !== ex_data[i]) begin
            n_fail++;
            $display("FAIL gap_write[%0d]: got a=%0d d=%h, required a=%0d d=%h", i,
                     wr_addr[i], wr_data[i], ex_addr[i], ex_data[i]);
         end
      end
      n_checks++;
      if (rdy_in_write != 0 || done_cyc.size() != 1) begin
         n_fail++; $display("FAIL gap_ready: ready-during-write=%0d done pulses=%0d, required 0 and 1",
                            rdy_in_write, done_cyc.size());
      end
   endtask

   task automatic test_abort_and_reset();
      sel = 1'b0;
      gen_img(4);
      do_start(1);
      send_img(0, -1);
      while (cyc + 1 - t0 < 8) @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      n_checks++;
      if ({o_we, o_err, o_hold, o_busy} !== 4'b0110) begin
         n_fail++; $display("FAIL abort_state: we/err/hold/busy=%b, required 0110", {o_we, o_err, o_hold, o_busy});
      end
      repeat (300) @(negedge clk);
      build_expected(1, 1'b1, 1'b1);
      while (ex_addr.size() > 4) begin
         void'(ex_addr.pop_back()); void'(ex_data.pop_back()); void'(ex_cyc.pop_back());
      end
      n_checks++;
      if (wr_addr.size() !== 4 || done_cyc.size() != 0) begin
         n_fail++; $display("FAIL abort_writes: writes=%0d done pulses=%0d, required 4 and 0",
                            wr_addr.size(), done_cyc.size());
      end
      for (int i = 0; i < ex_addr.size() && i < wr_addr.size(); i++) begin
         n_checks++;
         if (wr_addr[i] !== ex_addr[i] || wr_data[i] !== ex_data[i] || wr_cyc[i] !== ex_cyc[i]) begin
            n_fail++;
            $display("FAIL abort_write[%0d]: got a=%0d d=%h c=%0d, required a=%0d d=%h c=%0d", i,
                     wr_addr[i], wr_data[i], wr_cyc[i], ex_addr[i], ex_data[i], ex_cyc[i]);
         end
      end
      gen_img(8);
      do_start(2);
      send_byte(img[0], 0);
      send_byte(img[1], 0);
      rst_n = 1'b0;
      #1;
      n_checks++;
      if ({o_rdy, o_we, o_hold, o_busy, o_done, o_err} !== 6'b001000 || o_waddr !== '0 || o_wdata !== 32'h0) begin
         n_fail++;
         $display("FAIL midload_reset: flags=%b waddr=%0d wdata=%h, required 001000 0 0",
                  {o_rdy, o_we, o_hold, o_busy, o_done, o_err}, o_waddr, o_wdata);
      end
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_full_depth();
      sel = 1'b0;
      gen_img(4*DEPTH);
      do_start(DEPTH);
      send_img(0, 101);
      wait_idle(300);
      build_expected(DEPTH, 1'b1, 1'b1);
      n_checks++;
      if (wr_addr.size() !== DEPTH) begin
         n_fail++; $display("FAIL full_write_count: got %0d, required %0d", wr_addr.size(), DEPTH);
      end
      for (int i = 0; i < ex_addr.size() && i < wr_addr.size(); i++) begin
         n_checks++;
         if (wr_addr[i] !== ex_addr[i] || wr_data[i] !== ex_data[i] || wr_cyc[i] !== ex_cyc[i]) begin
            n_fail++;
            $display("FAIL full_write[%0d]: got a=%0d d=%h c=%0d, required a=%0d d=%h c=%0d", i,
                     wr_addr[i], wr_data[i], wr_cyc[i], ex_addr[i], ex_data[i], ex_cyc[i]);
         end
      end
      n_checks++;
      if (done_cyc.size() != 1 || done_cyc[0] != 5*DEPTH + 1 || hold_fall != 5*DEPTH + 2) begin
         n_fail++; $display("FAIL full_done: %0d pulses first at %0d hold fall %0d, required 1 at %0d fall %0d",
                            done_cyc.size(), (done_cyc.size() > 0) ? done_cyc[0] : -1, hold_fall,
                            5*DEPTH + 1, 5*DEPTH + 2);
      end
   endtask

   initial begin
      test_reset();
      test_big_endian_fill();
      test_little_endian();
      test_bad_count();
      test_gapped();
      test_abort_and_reset();
      test_full_depth();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
